hdmi_link_seq: RTL and testbench
================================

Name: hdmi_link_seq

Overview:
Hot-plug link sequencer for the HDMI TX path. Debounces HPD, powers up the transmitter, releases its reset, launches the register-config engine and supervises it with timeout and retry. All phase delays are counted in ticks from one external periodic timer instance. This block drives that timer's enable and restart inputs and consumes its one-cycle output pulse.

Parameters:
DEBOUNCE_TICKS, 16, ticks HPD must stay high before power-up (>=1)
PWRUP_TICKS, 8, ticks between tx_pwr_en rise and tx_rst_n release (>=1)
CFG_TIMEOUT_TICKS, 64, ticks allowed per config attempt (>=1)
MAX_RETRY, 3, config retries after the first attempt (0..15)
TICK_W, 16, tick counter width; every *_TICKS value must be < 2^TICK_W

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
hpd_in  in  1  raw hot-plug detect, asynchronous
tick_in  in  1  one-cycle pulse from the external timer
tmr_ena  out  1  timer enable
tmr_rst  out  1  timer restart, one-cycle pulse
tx_pwr_en  out  1  transmitter power enable
tx_rst_n  out  1  transmitter reset, active-low
cfg_start  out  1  one-cycle pulse; starts the config engine
cfg_done  in  1  config engine success, one-cycle pulse
cfg_err  in  1  config engine failure, one-cycle pulse
link_up  out  1  link configured and live
link_fail  out  1  retries exhausted
retry_cnt  out  4  retries consumed in the current plug session
state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; tick_cnt=0; retry_cnt=0; sync flops=0.
  - All outputs 0, including tx_rst_n=0.
  - Reset mid-sequence drops power immediately, on the same edge.
- HPD path: 2-flop synchroniser gives hpd_s. Latency hpd_in to hpd_s is 2 cycles. Only hpd_s is used.
- State encodings: IDLE=0, DEBOUNCE=1, PWR_UP=2, CONFIG=3, LINK_UP=4, FAIL=5.
- Entry events:
  - tmr_rst=1 and tmr_ena=0 in the first cycle of every newly entered state, including CONFIG re-entry on retry.
  - tick_cnt is cleared at the same point.
- Timed states (DEBOUNCE, PWR_UP, CONFIG):
  - tmr_ena=1 from the second cycle of the state on.
  - tick_cnt increments on tick_in, except in the tmr_rst cycle.
  - The timed condition fires on the Nth accepted tick, i.e. tick_in=1 while tick_cnt==N-1.
- tick_in is ignored in IDLE, LINK_UP, FAIL and in any tmr_rst cycle.
- HPD loss (hpd_s=0) in DEBOUNCE, PWR_UP, CONFIG, LINK_UP or FAIL:
  - Goes to IDLE next cycle.
  - Highest priority over every other event.
- IDLE:
  - Outputs deasserted; retry_cnt cleared.
  - hpd_s=1 goes to DEBOUNCE.
- DEBOUNCE: after DEBOUNCE_TICKS, go to PWR_UP.
- PWR_UP:
  - tx_pwr_en=1, tx_rst_n=0.
  - After PWRUP_TICKS, go to CONFIG.
- CONFIG:
  - tx_pwr_en=1, tx_rst_n=1.
  - cfg_start=1 in the entry cycle only.
  - cfg_done goes to LINK_UP.
  - cfg_err or timeout (CFG_TIMEOUT_TICKS) is a failure:
    - if retry_cnt<MAX_RETRY: retry_cnt+1 and re-enter CONFIG (new cfg_start, timer restarted);
    - otherwise go to FAIL.
  - cfg_done in the same cycle as cfg_err or timeout: cfg_done wins.
  - cfg_done/cfg_err in the entry cycle are accepted.
- LINK_UP: link_up=1, tx_pwr_en=1, tx_rst_n=1. Stays until HPD loss.
- FAIL:
  - link_fail=1, tx_pwr_en=0, tx_rst_n=0.
  - Stays until HPD loss; no automatic re-attempt.
- Output registering:
  - All outputs registered, decoded from next-state.
  - Each output changes on the same edge as state_dbg.
- retry_cnt saturates at MAX_RETRY. It is never decremented within a plug session.

Decomposition:
- Shared package hdmi_seq_pkg holds:
  - the state enumeration (3-bit, encodings above);
  - the default tick constants.
- One natural sub-module: hpd_sync, the 2-flop synchroniser.
- The external timer instance stays outside this block and is wired at the parent.

Test Plan:
Common setup:
- Parameters DEBOUNCE_TICKS=4, PWRUP_TICKS=2, CFG_TIMEOUT_TICKS=5, MAX_RETRY=2.
- The bench model pulses tick_in every 10 cycles while tmr_ena=1; the model restarts on tmr_rst.

Scenarios:
1. hpd_in rises and cfg_done is returned 3 cycles after cfg_start -> state_dbg walks 0,1,2,3,4; tx_pwr_en rises about 40 cycles after DEBOUNCE entry; tx_rst_n rises about 20 cycles later; exactly one cfg_start; link_up=1; retry_cnt=0.
2. hpd_in glitches low for 5 cycles during DEBOUNCE after 2 ticks -> back to IDLE; DEBOUNCE restarts with tick_cnt=0; tx_pwr_en is never asserted during the glitch.
3. CONFIG with cfg_done never returned -> 3 cfg_start pulses, each about 50 cycles apart; retry_cnt goes 0,1,2; then FAIL with link_fail=1, tx_pwr_en=0. Dropping hpd_in then gives IDLE and retry_cnt=0.
4. cfg_err on attempt 1, then cfg_done and cfg_err together on attempt 2 -> LINK_UP with retry_cnt=1.
5. rst_n=0 for 1 cycle while in LINK_UP -> next edge: all outputs 0, state_dbg=0. With hpd_in still high, the sequence reruns to LINK_UP.
6. hpd_in falls in the same cycle as the CONFIG timeout tick -> IDLE (HPD loss wins); retry_cnt cleared; no extra cfg_start.

Source files
------------

// File: rtl/hdmi_seq_pkg.sv
// Shared types and default tick budgets for the HDMI TX hot-plug link sequencer.
package hdmi_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_PWR_UP   = 3'd2,
      ST_CONFIG   = 3'd3,
      ST_LINK_UP  = 3'd4,
      ST_FAIL     = 3'd5
   } link_state_e;

   localparam int DEF_DEBOUNCE_TICKS    = 16;
   localparam int DEF_PWRUP_TICKS       = 8;
   localparam int DEF_CFG_TIMEOUT_TICKS = 64;
   localparam int DEF_MAX_RETRY         = 3;
   localparam int DEF_TICK_W            = 16;

   // States whose duration is measured in timer ticks.
   function automatic logic is_timed(input link_state_e s);
      return (s == ST_DEBOUNCE) || (s == ST_PWR_UP) || (s == ST_CONFIG);
   endfunction

endpackage

// File: rtl/hpd_sync.sv
// Two-flop synchroniser for the raw hot-plug detect; 2-cycle latency, no backpressure.
module hpd_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic hpd_in,
   output logic hpd_s
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta  <= 1'b0;
         hpd_s <= 1'b0;
      end else begin
         meta  <= hpd_in;
         hpd_s <= meta;
      end
   end

endmodule

// File: rtl/hdmi_link_seq.sv
// HDMI TX hot-plug sequencer: debounce, power-up, reset release, supervised config with retry.
// Outputs are registered from next-state, so they move on the same edge as state_dbg.
module hdmi_link_seq
   import hdmi_seq_pkg::*;
#(
   parameter int DEBOUNCE_TICKS    = DEF_DEBOUNCE_TICKS,
   parameter int PWRUP_TICKS       = DEF_PWRUP_TICKS,
   parameter int CFG_TIMEOUT_TICKS = DEF_CFG_TIMEOUT_TICKS,
   parameter int MAX_RETRY         = DEF_MAX_RETRY,
   parameter int TICK_W            = DEF_TICK_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hpd_in,
   input  logic       tick_in,
   output logic       tmr_ena,
   output logic       tmr_rst,
   output logic       tx_pwr_en,
   output logic       tx_rst_n,
   output logic       cfg_start,
   input  logic       cfg_done,
   input  logic       cfg_err,
   output logic       link_up,
   output logic       link_fail,
   output logic [3:0] retry_cnt,
   output logic [2:0] state_dbg
);

   // A phase ends when a tick arrives while the count already holds N-1.
   localparam logic [TICK_W-1:0] DEB_LAST = TICK_W'(DEBOUNCE_TICKS - 1);
   localparam logic [TICK_W-1:0] PWR_LAST = TICK_W'(PWRUP_TICKS - 1);
   localparam logic [TICK_W-1:0] CFG_LAST = TICK_W'(CFG_TIMEOUT_TICKS - 1);
   localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

   logic              hpd_s;
   link_state_e       state_q, state_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]        retry_q, retry_d;
   logic              reenter;
   logic              entering;
   logic              tick_ok;
   logic              cfg_fail;

   hpd_sync u_hpd_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .hpd_in (hpd_in),
      .hpd_s  (hpd_s)
   );

   // tmr_rst marks the first cycle of a state; ticks landing there are dropped.
   assign tick_ok  = tick_in && !tmr_rst && is_timed(state_q);
   assign cfg_fail = cfg_err || (tick_ok && (tick_cnt_q == CFG_LAST));

   always_comb begin
      state_d    = state_q;
      reenter    = 1'b0;
      retry_d    = retry_q;
      entering   = 1'b0;
      tick_cnt_d = tick_cnt_q;

      if ((state_q != ST_IDLE) && !hpd_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hpd_s) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
               if (tick_ok && (tick_cnt_q == DEB_LAST)) state_d = ST_PWR_UP;
            end
            ST_PWR_UP: begin
               if (tick_ok && (tick_cnt_q == PWR_LAST)) state_d = ST_CONFIG;
            end
            ST_CONFIG: begin
               if (cfg_done) begin
                  state_d = ST_LINK_UP;
               end else if (cfg_fail) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_d = retry_q + 4'd1;
                     reenter = 1'b1;
                  end else begin
                     state_d = ST_FAIL;
                  end
               end
            end
            default: begin
            end
         endcase
      end

      entering = (state_d != state_q) || reenter;

      if (entering)
         tick_cnt_d = '0;
      else if (tick_ok)
         tick_cnt_d = tick_cnt_q + TICK_W'(1);

      if (state_d == ST_IDLE)
         retry_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         retry_q    <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         retry_q    <= retry_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmr_rst   <= 1'b0;
         tmr_ena   <= 1'b0;
         tx_pwr_en <= 1'b0;
         tx_rst_n  <= 1'b0;
         cfg_start <= 1'b0;
         link_up   <= 1'b0;
         link_fail <= 1'b0;
      end else begin
         tmr_rst   <= entering;
         tmr_ena   <= is_timed(state_d) && !entering;
         tx_pwr_en <= (state_d == ST_PWR_UP) || (state_d == ST_CONFIG) || (state_d == ST_LINK_UP);
         tx_rst_n  <= (state_d == ST_CONFIG) || (state_d == ST_LINK_UP);
         cfg_start <= (state_d == ST_CONFIG) && entering;
         link_up   <= (state_d == ST_LINK_UP);
         link_fail <= (state_d == ST_FAIL);
      end
   end

   assign retry_cnt = retry_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_hdmi_link_seq.sv
// Bench for hdmi_link_seq: directed scenarios plus randomized plug sessions against a behavioural model.
module tb_hdmi_link_seq;

   localparam int DEB = 4;
   localparam int PWU = 2;
   localparam int CTO = 5;
   localparam int MR  = 2;
   // With a tick every 10 enabled cycles, an N-tick phase spans 10*N+2 cycles.
   localparam int DEB_SPAN = 10 * DEB + 2;
   localparam int PWU_SPAN = 10 * PWU + 2;
   localparam int CTO_SPAN = 10 * CTO + 2;

   logic       clk = 1'b0;
   logic       rst_n, hpd_in, tick_in, cfg_done, cfg_err;
   logic       tmr_ena, tmr_rst, tx_pwr_en, tx_rst_n, cfg_start, link_up, link_fail;
   logic [3:0] retry_cnt;
   logic [2:0] state_dbg;

   hdmi_link_seq #(
      .DEBOUNCE_TICKS    (DEB),
      .PWRUP_TICKS       (PWU),
      .CFG_TIMEOUT_TICKS (CTO),
      .MAX_RETRY         (MR),
      .TICK_W            (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hpd_in    (hpd_in),
      .tick_in   (tick_in),
      .tmr_ena   (tmr_ena),
      .tmr_rst   (tmr_rst),
      .tx_pwr_en (tx_pwr_en),
      .tx_rst_n  (tx_rst_n),
      .cfg_start (cfg_start),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .link_up   (link_up),
      .link_fail (link_fail),
      .retry_cnt (retry_cnt),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   logic [13:0] dut_vec;
   assign dut_vec = {state_dbg, tmr_ena, tmr_rst, tx_pwr_en, tx_rst_n, cfg_start,
                     link_up, link_fail, retry_cnt};

   // Stimulus-side environment: external timer and config engine responder.
   bit rand_mode = 0;
   int plan[$];

   initial begin
      logic r, e;
      int tcnt, pend, code;
      tick_in = 0; cfg_done = 0; cfg_err = 0;
      tcnt = 0; pend = 0; code = 0;
      forever begin
         @(negedge clk);
         r = tmr_rst;
         e = tmr_ena;
         if (cfg_start === 1'b1) begin
            if (rand_mode) begin
               code = $urandom_range(0, 3);
               pend = $urandom_range(1, 12);
            end else begin
               code = (plan.size() > 0) ? plan.pop_front() : 0;
               pend = 3;
            end
            if (code == 0) pend = 0;
         end
         @(posedge clk);
         #1;
         tick_in = 0; cfg_done = 0; cfg_err = 0;
         if (r === 1'b1) tcnt = 0;
         else if (e === 1'b1) begin
            if (tcnt == 9) begin
               tcnt = 0;
               tick_in = 1;
            end else tcnt++;
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               cfg_done = code[0];
               cfg_err  = code[1];
            end
         end
         if (rand_mode && $urandom_range(0, 39) == 0) begin
            if ($urandom_range(0, 1) == 1) cfg_done = 1;
            else cfg_err = 1;
         end
      end
   end

   // Behavioural model: phase number, accepted-tick tally, retries used.
   int m_s1, m_s2, m_st, m_ticks, m_retry;
   bit m_fresh, m_start, model_valid = 0;

   function automatic bit timed(input int s);
      return s == 1 || s == 2 || s == 3;
   endfunction

   task automatic model_step;
      int hs, nxt, t;
      bit again;
      if (rst_n !== 1'b1) begin
         m_s1 = 0; m_s2 = 0; m_st = 0; m_ticks = 0; m_retry = 0;
         m_fresh = 0; m_start = 0;
      end else begin
         hs   = m_s2;
         m_s2 = m_s1;
         m_s1 = int'(hpd_in);
         t    = m_ticks + int'(tick_in && !m_fresh && timed(m_st));
         nxt  = m_st;
         again = 0;
         if (m_st != 0 && hs == 0) nxt = 0;
         else begin
            case (m_st)
               0: if (hs == 1) nxt = 1;
               1: if (t == DEB) nxt = 2;
               2: if (t == PWU) nxt = 3;
               3: begin
                  if (cfg_done) nxt = 4;
                  else if (cfg_err || t == CTO) begin
                     if (m_retry < MR) begin
                        m_retry++;
                        again = 1;
                     end else nxt = 5;
                  end
               end
               default: ;
            endcase
         end
         m_fresh = (nxt != m_st) || again;
         m_start = (nxt == 3) && m_fresh;
         m_ticks = m_fresh ? 0 : t;
         if (nxt == 0) m_retry = 0;
         m_st = nxt;
      end
   endtask

   function automatic logic [13:0] model_vec();
      return {3'(m_st), timed(m_st) && !m_fresh, m_fresh, m_st >= 2 && m_st <= 4,
              m_st == 3 || m_st == 4, m_start, m_st == 4, m_st == 5, 4'(m_retry)};
   endfunction

   // Event log read back by the directed scenarios.
   int cyc = 0, t_deb, t_pwr, t_txr, t_idle, t_lasttick, n_start, deb_ticks, cfg_ticks;
   int prev_state = 0;
   bit prev_pwr = 0, prev_txr = 0, pwr_seen = 0;
   int walk[$], start_cyc[$], start_retry[$];

   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            n_checks++;
            if (dut_vec !== model_vec()) begin
               n_fail++;
               $display("FAIL cycle_model @%0d: dut=%b model=%b", cyc, dut_vec, model_vec());
            end
            cyc++;
            if (int'(state_dbg) != prev_state) walk.push_back(int'(state_dbg));
            if (state_dbg == 3'd1 && tmr_rst) begin t_deb = cyc; deb_ticks = 0; end
            else if (state_dbg == 3'd1 && tick_in) deb_ticks++;
            if (state_dbg == 3'd3 && tmr_rst) cfg_ticks = 0;
            else if (state_dbg == 3'd3 && tick_in) begin cfg_ticks++; t_lasttick = cyc; end
            if (tx_pwr_en && !prev_pwr) t_pwr = cyc;
            if (tx_rst_n && !prev_txr) t_txr = cyc;
            if (tx_pwr_en) pwr_seen = 1;
            if (state_dbg == 3'd0 && prev_state != 0) t_idle = cyc;
            if (cfg_start) begin
               n_start++;
               start_cyc.push_back(cyc);
               start_retry.push_back(int'(retry_cnt));
            end
            prev_state = int'(state_dbg);
            prev_pwr   = tx_pwr_en;
            prev_txr   = tx_rst_n;
         end
         model_step();
         model_valid = 1;
      end
   end

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic drive_edge;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_st(input string name, input int s, input int budget);
      int i = 0;
      while (int'(state_dbg) != s && i < budget) begin
         step();
         i++;
      end
      chk(name, int'(state_dbg), s);
   endtask

   task automatic clear_log;
      walk.delete();
      start_cyc.delete();
      start_retry.delete();
      n_start  = 0;
      pwr_seen = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      rst_n = 0; hpd_in = 0;
      repeat (3) drive_edge();
      rst_n = 1;
      step();
      chk("reset_outputs", int'(dut_vec), 0);
      chk("reset_tx_rst_n", int'(tx_rst_n), 0);

      // 1: clean bring-up
      clear_log();
      plan.push_back(1);
      drive_edge(); hpd_in = 1;
      wait_st("s1_link_up_state", 4, 400);
      chk("s1_walk_len", walk.size(), 4);
      for (int k = 0; k < walk.size() && k < 4; k++) chk("s1_walk", walk[k], k + 1);
      chk("s1_pwr_delay", t_pwr - t_deb, DEB_SPAN);
      chk("s1_txrst_delay", t_txr - t_pwr, PWU_SPAN);
      chk("s1_cfg_starts", n_start, 1);
      chk("s1_link_up", int'(link_up), 1);
      chk("s1_retry", int'(retry_cnt), 0);

      // 2: HPD glitch during debounce
      drive_edge(); hpd_in = 0;
      wait_st("s2_idle_first", 0, 10);
      clear_log();
      plan.push_back(1);
      drive_edge(); hpd_in = 1;
      wait_st("s2_debounce", 1, 10);
      i = 0;
      while (deb_ticks < 2 && i < 100) begin step(); i++; end
      chk("s2_two_ticks", deb_ticks, 2);
      pwr_seen = 0;
      drive_edge(); hpd_in = 0;
      repeat (4) drive_edge();
      drive_edge(); hpd_in = 1;
      wait_st("s2_glitch_idle", 0, 10);
      wait_st("s2_redebounce", 1, 10);
      chk("s2_no_pwr_in_glitch", int'(pwr_seen), 0);
      wait_st("s2_pwr_up", 2, 100);
      chk("s2_full_debounce", t_pwr - t_deb, DEB_SPAN);
      wait_st("s2_link_up", 4, 200);

      // 3: config never answers
      drive_edge(); hpd_in = 0;
      wait_st("s3_idle_first", 0, 10);
      clear_log();
      drive_edge(); hpd_in = 1;
      wait_st("s3_fail_state", 5, 600);
      chk("s3_cfg_starts", n_start, 3);
      for (int k = 0; k < start_retry.size() && k < 3; k++) chk("s3_retry_at_start", start_retry[k], k);
      for (int k = 1; k < start_cyc.size() && k < 3; k++)
         chk("s3_start_spacing", start_cyc[k] - start_cyc[k-1], CTO_SPAN);
      chk("s3_link_fail", int'(link_fail), 1);
      chk("s3_pwr_off", int'(tx_pwr_en), 0);
      chk("s3_retry_sat", int'(retry_cnt), 2);
      drive_edge(); hpd_in = 0;
      wait_st("s3_unplug_idle", 0, 10);
      chk("s3_retry_cleared", int'(retry_cnt), 0);
      chk("s3_fail_cleared", int'(link_fail), 0);

      // 4: err, then done+err together
      clear_log();
      plan.push_back(2);
      plan.push_back(3);
      drive_edge(); hpd_in = 1;
      wait_st("s4_link_up", 4, 400);
      chk("s4_cfg_starts", n_start, 2);
      chk("s4_retry", int'(retry_cnt), 1);

      // 5: one-cycle reset while live
      drive_edge(); rst_n = 0;
      drive_edge(); rst_n = 1;
      step();
      chk("s5_reset_outputs", int'(dut_vec), 0);
      plan.push_back(1);
      wait_st("s5_relink", 4, 400);
      chk("s5_link_up", int'(link_up), 1);

      // 6: HPD loss coincides with the timeout tick
      drive_edge(); hpd_in = 0;
      wait_st("s6_idle_first", 0, 10);
      clear_log();
      drive_edge(); hpd_in = 1;
      wait_st("s6_config", 3, 200);
      i = 0;
      while (cfg_ticks < CTO - 1 && i < 100) begin step(); i++; end
      chk("s6_ticks_before", cfg_ticks, CTO - 1);
      repeat (8) drive_edge();
      hpd_in = 0;
      wait_st("s6_idle", 0, 20);
      chk("s6_coincide", t_idle - t_lasttick, 1);
      chk("s6_retry", int'(retry_cnt), 0);
      repeat (5) step();
      chk("s6_one_start", n_start, 1);
      chk("s6_stays_idle", int'(state_dbg), 0);

      // Randomized plug sessions, checked cycle by cycle against the model.
      rand_mode = 1;
      for (int s = 0; s < 15; s++) begin
         int hold;
         drive_edge(); hpd_in = 1;
         hold = $urandom_range(5, 450);
         for (int c = 0; c < hold; c++) begin
            drive_edge();
            if (s % 4 == 3 && c == hold / 2) rst_n = 0;
            else rst_n = 1;
            if ($urandom_range(0, 99) == 0) hpd_in = ~hpd_in;
            else hpd_in = 1;
         end
         rst_n = 1;
         hpd_in = 0;
         repeat ($urandom_range(3, 20)) drive_edge();
      end
      rand_mode = 0;
      repeat (20) drive_edge();
      step();
      chk("rand_end_idle", int'(state_dbg), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
